// File: rtl/regdst_pipe_pkg.sv
// Shared MIPS register-file constants and destination-select encodings.
package mips_pkg;

  localparam int REG_AW = 5;
  localparam logic [REG_AW-1:0] REG_ZERO = '0;
  localparam logic [REG_AW-1:0] REG_LINK = 5'd31;
  localparam int PIPE_DEPTH = 3;

  localparam int SEL_RT = 0;
  localparam int SEL_RD = 1;

  // Default two-candidate encoding; any code above link means "no write".
  typedef enum logic [1:0] {
    SEL_E_RT   = 2'd0,
    SEL_E_RD   = 2'd1,
    SEL_E_LINK = 2'd2,
    SEL_E_NONE = 2'd3
  } dst_sel_e;

  function automatic int sel_link(input int nsrc);
    return nsrc;
  endfunction

endpackage

// File: rtl/regdst_pipe_dst_addr_select.sv
// Combinational NSRC-way write-back address resolver with a write-qualify bit.
module dst_addr_select
  import mips_pkg::*;
#(
  parameter int AW        = REG_AW,
  parameter int NSRC      = 2,
  parameter int LINK_ADDR = 31,
  parameter int SW        = $clog2(NSRC + 2)
) (
  input  logic [NSRC*AW-1:0] addr_i,
  input  logic [SW-1:0]      sel_i,
  output logic [AW-1:0]      addr_o,
  output logic               wq_o
);

  localparam logic [SW-1:0] SelLink = SW'(sel_link(NSRC));

  always_comb begin
    addr_o = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (sel_i == SW'(i)) begin
        addr_o = addr_i[i*AW +: AW];
      end
    end
    if (sel_i == SelLink) begin
      addr_o = AW'(LINK_ADDR);
    end
  end

  // Writes to $0 never qualify, so an unqualified result always carries address 0 for $0.
  assign wq_o = (sel_i <= SelLink) && (addr_o != '0);

endmodule

// File: rtl/regdst_pipe.sv
// Destination-register selector and per-stage tracker with nearest-stage forwarding match.
module regdst_pipe
  import mips_pkg::*;
#(
  parameter int AW        = REG_AW,
  parameter int NSRC      = 2,
  parameter int DEPTH     = PIPE_DEPTH,
  parameter int LINK_ADDR = 31,
  parameter int SW        = $clog2(NSRC + 2)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [NSRC*AW-1:0]  addr_in,
  input  logic [SW-1:0]       sel,
  input  logic                we_in,
  input  logic                stall,
  input  logic                flush,
  input  logic [AW-1:0]       rs_q,
  input  logic [AW-1:0]       rt_q,
  output logic [DEPTH*AW-1:0] stage_addr,
  output logic [DEPTH-1:0]    stage_we,
  output logic [DEPTH-1:0]    fwd_rs,
  output logic [DEPTH-1:0]    fwd_rt
);

  logic [AW-1:0] res_addr;
  logic          res_wq;
  logic          res_we;

  dst_addr_select #(
    .AW       (AW),
    .NSRC     (NSRC),
    .LINK_ADDR(LINK_ADDR),
    .SW       (SW)
  ) u_sel (
    .addr_i(addr_in),
    .sel_i (sel),
    .addr_o(res_addr),
    .wq_o  (res_wq)
  );

  assign res_we = in_valid & we_in & res_wq;

  logic [AW-1:0]    addr_q [DEPTH];
  logic [AW-1:0]    addr_d [DEPTH];
  logic [DEPTH-1:0] we_q;
  logic [DEPTH-1:0] we_d;
  logic [DEPTH-1:0] hit_rs;
  logic [DEPTH-1:0] hit_rt;
  logic [DEPTH-1:0] seen_rs;
  logic [DEPTH-1:0] seen_rt;

  assign seen_rs[0] = 1'b0;
  assign seen_rt[0] = 1'b0;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    if (gi == 0) begin : g_head
      assign addr_d[gi] = flush ? '0   : (stall ? addr_q[gi] : res_addr);
      assign we_d[gi]   = flush ? 1'b0 : (stall ? we_q[gi]   : res_we);
    end else if (gi == 1) begin : g_bubble
      // Stage 0 is held or squashed, so stage 1 must not duplicate it.
      assign addr_d[gi] = (stall | flush) ? '0   : addr_q[gi-1];
      assign we_d[gi]   = (stall | flush) ? 1'b0 : we_q[gi-1];
    end else begin : g_shift
      assign addr_d[gi] = addr_q[gi-1];
      assign we_d[gi]   = we_q[gi-1];
    end

    assign stage_addr[gi*AW +: AW] = addr_q[gi];
    assign stage_we[gi]            = we_q[gi];

    assign hit_rs[gi] = we_q[gi] && (addr_q[gi] == rs_q) && (rs_q != REG_ZERO);
    assign hit_rt[gi] = we_q[gi] && (addr_q[gi] == rt_q) && (rt_q != REG_ZERO);
    assign fwd_rs[gi] = hit_rs[gi] & ~seen_rs[gi];
    assign fwd_rt[gi] = hit_rt[gi] & ~seen_rt[gi];

    if (gi < DEPTH - 1) begin : g_chain
      assign seen_rs[gi+1] = seen_rs[gi] | hit_rs[gi];
      assign seen_rt[gi+1] = seen_rt[gi] | hit_rt[gi];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        addr_q[k] <= '0;
      end
      we_q <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        addr_q[k] <= addr_d[k];
      end
      we_q <= we_d;
    end
  end

endmodule

// File: tb/tb_regdst_pipe.sv
// Scoreboard bench for regdst_pipe: expected stage state queued at drive time, compared after the edge.
module tb_regdst_pipe;

  localparam int AW    = 5;
  localparam int NSRC  = 2;
  localparam int DEPTH = 3;
  localparam int SW    = 2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                in_valid = 1'b0;
  logic [NSRC*AW-1:0]  addr_in = '0;
  logic [SW-1:0]       sel = '0;
  logic                we_in = 1'b0;
  logic                stall = 1'b0;
  logic                flush = 1'b0;
  logic [AW-1:0]       rs_q = '0;
  logic [AW-1:0]       rt_q = '0;
  logic [DEPTH*AW-1:0] stage_addr;
  logic [DEPTH-1:0]    stage_we;
  logic [DEPTH-1:0]    fwd_rs;
  logic [DEPTH-1:0]    fwd_rt;

  regdst_pipe #(
    .AW(AW), .NSRC(NSRC), .DEPTH(DEPTH), .LINK_ADDR(31)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .addr_in(addr_in), .sel(sel),
    .we_in(we_in), .stall(stall), .flush(flush), .rs_q(rs_q), .rt_q(rt_q),
    .stage_addr(stage_addr), .stage_we(stage_we), .fwd_rs(fwd_rs), .fwd_rt(fwd_rt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DEPTH*AW-1:0] addr;
    logic [DEPTH-1:0]    we;
  } snap_t;

  typedef struct packed {
    logic               v;
    logic [NSRC*AW-1:0] a;
    logic [SW-1:0]      s;
    logic               w;
    logic               st;
    logic               fl;
  } stim_t;

  localparam stim_t IDLE = '{v: 1'b0, a: '0, s: 2'd0, w: 1'b0, st: 1'b0, fl: 1'b0};

  snap_t         exp_q[$];
  logic [AW-1:0] m_addr [DEPTH];
  logic          m_we   [DEPTH];
  int            checks = 0;
  int            failures = 0;

  task automatic model_reset();
    for (int k = 0; k < DEPTH; k++) begin
      m_addr[k] = '0;
      m_we[k]   = 1'b0;
    end
    exp_q.delete();
  endtask

  // Apply one row to the DUT inputs, advance the reference model, queue the expected state.
  task automatic drive(input stim_t r);
    logic [AW-1:0] ra;
    logic          rw;
    snap_t         e;
    in_valid = r.v; addr_in = r.a; sel = r.s; we_in = r.w; stall = r.st; flush = r.fl;
    if (int'(r.s) < NSRC)       ra = r.a[int'(r.s)*AW +: AW];
    else if (int'(r.s) == NSRC) ra = 5'd31;
    else                        ra = '0;
    rw = r.v & r.w & (int'(r.s) <= NSRC) & (ra != '0);
    for (int k = DEPTH - 1; k >= 2; k--) begin
      m_addr[k] = m_addr[k-1];
      m_we[k]   = m_we[k-1];
    end
    m_addr[1] = (r.st | r.fl) ? '0 : m_addr[0];
    m_we[1]   = (r.st | r.fl) ? 1'b0 : m_we[0];
    if (r.fl) begin
      m_addr[0] = '0; m_we[0] = 1'b0;
    end else if (!r.st) begin
      m_addr[0] = ra; m_we[0] = rw;
    end
    for (int k = 0; k < DEPTH; k++) begin
      e.addr[k*AW +: AW] = m_addr[k];
      e.we[k]            = m_we[k];
    end
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic stim_t row(input logic [AW-1:0] hi, input logic [AW-1:0] lo,
                                input logic [SW-1:0] s, input logic w,
                                input logic st, input logic fl);
    row = '{v: 1'b1, a: {hi, lo}, s: s, w: w, st: st, fl: fl};
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; addr_in = NSRC*AW'($urandom); sel = SW'($urandom);
      we_in = 1'b1; stall = 1'($urandom); flush = 1'($urandom);
      rs_q = AW'($urandom); rt_q = AW'($urandom);
      tick();
      checks++;
      if (stage_addr !== '0) begin
        failures++; $display("FAIL reset_addr: got %h want 0", stage_addr);
      end
      checks++;
      if (stage_we !== '0) begin
        failures++; $display("FAIL reset_we: got %b want 000", stage_we);
      end
      checks++;
      if (fwd_rs !== '0 || fwd_rt !== '0) begin
        failures++; $display("FAIL reset_fwd: got rs=%b rt=%b want 000/000", fwd_rs, fwd_rt);
      end
    end
    drive(IDLE);
    exp_q.delete();
    rs_q = '0; rt_q = '0;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_select();
    stim_t rows [5];
    snap_t e;
    rows = '{row(5'd9, 5'd4, 2'd1, 1'b1, 1'b0, 1'b0), IDLE, IDLE,
             row(5'd9, 5'd4, 2'd2, 1'b1, 1'b0, 1'b0),
             row(5'd9, 5'd4, 2'd3, 1'b1, 1'b0, 1'b0)};
    for (int i = 0; i < 5; i++) begin
      drive(rows[i]);
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({stage_addr, stage_we} !== {e.addr, e.we}) begin
        failures++;
        $display("FAIL select_sb[%0d]: got addr=%h we=%b want addr=%h we=%b", i, stage_addr, stage_we, e.addr, e.we);
      end
      if (i == 0) begin
        checks++;
        if (stage_addr[4:0] !== 5'd9 || stage_we[0] !== 1'b1) begin
          failures++; $display("FAIL select_rd_s0: got %0d/%b want 9/1", stage_addr[4:0], stage_we[0]);
        end
      end
      if (i == 2) begin
        checks++;
        if (stage_addr[14:10] !== 5'd9 || stage_we[2] !== 1'b1) begin
          failures++; $display("FAIL select_rd_s2: got %0d/%b want 9/1", stage_addr[14:10], stage_we[2]);
        end
      end
      if (i == 3) begin
        checks++;
        if (stage_addr[4:0] !== 5'd31 || stage_we[0] !== 1'b1) begin
          failures++; $display("FAIL select_link: got %0d/%b want 31/1", stage_addr[4:0], stage_we[0]);
        end
      end
      if (i == 4) begin
        checks++;
        if (stage_we[0] !== 1'b0) begin
          failures++; $display("FAIL select_nowrite: got we=%b want 0", stage_we[0]);
        end
      end
    end
  endtask

  task automatic test_zero();
    snap_t e;
    drive(row(5'd9, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0));
    tick();
    e = exp_q.pop_front();
    checks++;
    if ({stage_addr, stage_we} !== {e.addr, e.we}) begin
      failures++;
      $display("FAIL zero_sb: got addr=%h we=%b want addr=%h we=%b", stage_addr, stage_we, e.addr, e.we);
    end
    checks++;
    if (stage_we[0] !== 1'b0 || stage_addr[4:0] !== 5'd0) begin
      failures++; $display("FAIL zero_squash: got %0d/%b want 0/0", stage_addr[4:0], stage_we[0]);
    end
    rs_q = 5'd0; rt_q = 5'd31;
    #1;
    checks++;
    if (fwd_rs !== 3'b000) begin
      failures++; $display("FAIL zero_fwd_rs: got %b want 000", fwd_rs);
    end
    checks++;
    if (fwd_rt !== 3'b100) begin
      failures++; $display("FAIL zero_fwd_link: got %b want 100", fwd_rt);
    end
  endtask

  task automatic test_priority();
    stim_t rows [5];
    snap_t e;
    rows = '{row(5'd0, 5'd7, 2'd0, 1'b1, 1'b0, 1'b0),
             row(5'd0, 5'd3, 2'd0, 1'b1, 1'b0, 1'b0),
             row(5'd0, 5'd7, 2'd0, 1'b1, 1'b0, 1'b0),
             row(5'd0, 5'd9, 2'd0, 1'b1, 1'b0, 1'b0),
             row(5'd0, 5'd7, 2'd0, 1'b0, 1'b0, 1'b0)};
    rs_q = 5'd7; rt_q = 5'd3;
    for (int i = 0; i < 5; i++) begin
      drive(rows[i]);
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({stage_addr, stage_we} !== {e.addr, e.we}) begin
        failures++;
        $display("FAIL prio_sb[%0d]: got addr=%h we=%b want addr=%h we=%b", i, stage_addr, stage_we, e.addr, e.we);
      end
      if (i == 2) begin
        checks++;
        if (fwd_rs !== 3'b001 || fwd_rt !== 3'b010) begin
          failures++; $display("FAIL prio_nearest: got rs=%b rt=%b want 001/010", fwd_rs, fwd_rt);
        end
      end
      if (i == 4) begin
        checks++;
        if (fwd_rs !== 3'b100) begin
          failures++; $display("FAIL prio_skip_we0: got rs=%b want 100", fwd_rs);
        end
      end
    end
  endtask

  task automatic test_stall();
    stim_t rows [6];
    snap_t e;
    rows = '{row(5'd0, 5'd10, 2'd0, 1'b1, 1'b0, 1'b0),
             row(5'd0, 5'd11, 2'd0, 1'b1, 1'b0, 1'b0),
             row(5'd0, 5'd12, 2'd0, 1'b1, 1'b0, 1'b0),
             row(5'd0, 5'd20, 2'd0, 1'b1, 1'b1, 1'b0),
             row(5'd0, 5'd20, 2'd0, 1'b1, 1'b1, 1'b0),
             row(5'd0, 5'd20, 2'd0, 1'b1, 1'b0, 1'b0)};
    for (int i = 0; i < 6; i++) begin
      drive(rows[i]);
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({stage_addr, stage_we} !== {e.addr, e.we}) begin
        failures++;
        $display("FAIL stall_sb[%0d]: got addr=%h we=%b want addr=%h we=%b", i, stage_addr, stage_we, e.addr, e.we);
      end
      if (i == 3) begin
        checks++;
        if (stage_addr[4:0] !== 5'd12 || stage_we[1] !== 1'b0 || stage_addr[14:10] !== 5'd11 || stage_we[2] !== 1'b1) begin
          failures++;
          $display("FAIL stall_first: got s0=%0d we1=%b s2=%0d we2=%b want 12/0/11/1",
                   stage_addr[4:0], stage_we[1], stage_addr[14:10], stage_we[2]);
        end
      end
      if (i == 4) begin
        checks++;
        if (stage_addr[4:0] !== 5'd12 || stage_we[1] !== 1'b0 || stage_we[2] !== 1'b0) begin
          failures++;
          $display("FAIL stall_second: got s0=%0d we=%b want s0=12 we[2:1]=00", stage_addr[4:0], stage_we);
        end
      end
      if (i == 5) begin
        checks++;
        if (stage_addr[9:5] !== 5'd12 || stage_we[1] !== 1'b1 || stage_addr[4:0] !== 5'd20) begin
          failures++;
          $display("FAIL stall_release: got s0=%0d s1=%0d we=%b want 20/12 we1=1", stage_addr[4:0], stage_addr[9:5], stage_we);
        end
      end
    end
  endtask

  task automatic test_flush_stall();
    stim_t rows [4];
    snap_t e;
    rows = '{row(5'd0, 5'd13, 2'd0, 1'b1, 1'b0, 1'b0),
             row(5'd0, 5'd14, 2'd0, 1'b1, 1'b0, 1'b0),
             row(5'd0, 5'd5,  2'd0, 1'b1, 1'b1, 1'b1),
             row(5'd0, 5'd6,  2'd0, 1'b1, 1'b0, 1'b1)};
    for (int i = 0; i < 4; i++) begin
      drive(rows[i]);
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({stage_addr, stage_we} !== {e.addr, e.we}) begin
        failures++;
        $display("FAIL flush_sb[%0d]: got addr=%h we=%b want addr=%h we=%b", i, stage_addr, stage_we, e.addr, e.we);
      end
      if (i == 2) begin
        checks++;
        if (stage_we !== 3'b100 || stage_addr[14:10] !== 5'd13) begin
          failures++;
          $display("FAIL flush_stall: got we=%b s2=%0d want 100/13", stage_we, stage_addr[14:10]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t r;
    snap_t e;
    logic [DEPTH-1:0] ers, ert;
    logic frs, frt;
    for (int i = 0; i < 40; i++) begin
      r = '{v: 1'($urandom_range(0, 3) != 0), a: NSRC*AW'($urandom), s: SW'($urandom),
            w: 1'($urandom_range(0, 3) != 0), st: 1'($urandom_range(0, 5) == 0),
            fl: 1'($urandom_range(0, 7) == 0)};
      drive(r);
      tick();
      rs_q = ($urandom_range(0, 1) == 1) ? m_addr[$urandom_range(0, DEPTH-1)] : AW'($urandom);
      rt_q = ($urandom_range(0, 1) == 1) ? m_addr[$urandom_range(0, DEPTH-1)] : AW'($urandom);
      #1;
      e = exp_q.pop_front();
      checks++;
      if ({stage_addr, stage_we} !== {e.addr, e.we}) begin
        failures++;
        $display("FAIL b2b_sb[%0d]: got addr=%h we=%b want addr=%h we=%b", i, stage_addr, stage_we, e.addr, e.we);
      end
      ers = '0; ert = '0; frs = 1'b0; frt = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
        if (!frs && m_we[k] && m_addr[k] == rs_q && rs_q != '0) begin ers[k] = 1'b1; frs = 1'b1; end
        if (!frt && m_we[k] && m_addr[k] == rt_q && rt_q != '0) begin ert[k] = 1'b1; frt = 1'b1; end
      end
      checks++;
      if (fwd_rs !== ers || fwd_rt !== ert) begin
        failures++;
        $display("FAIL b2b_fwd[%0d]: got rs=%b rt=%b want rs=%b rt=%b", i, fwd_rs, fwd_rt, ers, ert);
      end
    end
  endtask

  task automatic test_reset_mid();
    snap_t e;
    drive(row(5'd0, 5'd15, 2'd0, 1'b1, 1'b0, 1'b0));
    tick();
    e = exp_q.pop_front();
    checks++;
    if ({stage_addr, stage_we} !== {e.addr, e.we}) begin
      failures++;
      $display("FAIL midrst_pre: got addr=%h we=%b want addr=%h we=%b", stage_addr, stage_we, e.addr, e.we);
    end
    rs_q = 5'd15;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (stage_addr !== '0 || stage_we !== '0 || fwd_rs !== '0) begin
      failures++;
      $display("FAIL midrst_clear: got addr=%h we=%b fwd_rs=%b want all 0", stage_addr, stage_we, fwd_rs);
    end
    model_reset();
    drive(IDLE);
    exp_q.delete();
    model_reset();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_select();
    test_zero();
    test_priority();
    test_stall();
    test_flush_stall();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regdst_pipe.md
# regdst_pipe

Parametrised destination-register selector and tracker for the pipelined MIPS core. It resolves the write-back register address from NSRC candidate fields, the link constant or "no write", registers the result, and carries it with its write-enable through DEPTH pipeline stages (EX/MEM/WB by default). It also supplies one-hot forwarding-match vectors for two source-register queries. It replaces the fixed 5-bit 2:1 RegDst select and the ad-hoc per-stage destination registers.

## Interface
Parameters:
- AW, 5, register address width
- NSRC, 2, number of candidate address fields (default rt, rd)
- DEPTH, 3, number of tracked stages (index 0 = earliest)
- LINK_ADDR, 31, address selected for link instructions (jal)
- SW, $clog2(NSRC+2), select width (derived, not overridden)

Ports. One clock; reset is asynchronous and active-low (`rst_n`):
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decode stage presents a valid instruction
- addr_in  in  NSRC*AW  candidate fields, slice i = addr_in[i*AW +: AW]
- sel  in  SW  0..NSRC-1 pick slice, NSRC pick LINK_ADDR, >NSRC no write
- we_in  in  1  instruction writes a register
- stall  in  1  hold stage 0, inject bubble into stage 1
- flush  in  1  squash the instruction entering stage 0
- rs_q, rt_q  in  AW each  source-register queries
- stage_addr  out  DEPTH*AW  registered destination per stage
- stage_we  out  DEPTH  registered write-enable per stage
- fwd_rs, fwd_rt  out  DEPTH each  one-hot nearest-stage match

## Operation
- Resolve: addr = slice[sel] if sel<NSRC; LINK_ADDR if sel==NSRC; 0 otherwise.
- Resolved we = in_valid & we_in & (sel<=NSRC) & (addr!=0). Writes to $0 are squashed, and the stored address is then 0.
- Stage 0 load: flush → addr 0, we 0. Otherwise, stall → hold. Otherwise → resolved addr/we.
- Stage 1 load: stall or flush → addr 0, we 0 (bubble). Otherwise → stage 0.
- Stages k≥2 always load stage k-1. Stall does not freeze the downstream stages.
- flush and stall together: stage 0 becomes a bubble, stage 1 becomes a bubble, the rest advance.
- Forwarding: fwd_rs[k]=1 only for the smallest k with stage_we[k] & stage_addr[k]==rs_q & rs_q!=0. Otherwise the bit is 0. fwd_rt works the same way. Each vector is one-hot or all zero.
- Forwarding is purely combinational from the stage registers and the query inputs.

## Timing
- Reset (rst_n=0, asynchronous assert): every stage_addr=0, every stage_we=0, hence fwd_*=0. Release is synchronised by the core's reset bridge.
- Latency: inputs to stage_addr[0]/stage_we[0] in 1 cycle. Stage k follows k+1 cycles later with no stall.
- A stall cycle adds 1 cycle of latency for the instruction held in stage 0 only.
- fwd_* reflect the current register state in the same cycle as the query (0-cycle path).
- Reset asserted mid-stream clears all stages immediately, with no partial drain.

## Structure
- Shared package `mips_pkg`: REG_AW=5, REG_ZERO=0, REG_LINK=31, DEPTH default, sel encodings (SEL_RT=0, SEL_RD=1, SEL_LINK=NSRC).
- Sub-module `dst_addr_select`: combinational NSRC-way resolver producing addr and a write-qualify bit. It is reused by the branch/link unit.
- Stage registers and the priority match are written as generate loops over DEPTH.

## Test plan
- Reset: hold rst_n=0 with random inputs → all stage_we=0, stage_addr=0, fwd_rs=fwd_rt=0.
- Select: sel=1, addr_in={rd=9, rt=4}, we_in=1 → stage_addr[0]=9 after 1 cycle, stage_addr[2]=9 after 3 cycles. sel=2 → 31. sel=3 → we 0.
- $0 squash: sel=0, rt=0, we_in=1 → stage_we[0]=0. rs_q=0 never sets fwd_rs.
- Priority: stages hold addr 7 in stages 0 and 2, both we=1, rs_q=7 → fwd_rs=3'b001. Stage 0 we=0 → 3'b100.
- Stall: stall=1 for 2 cycles with addr 12 in stage 0 → stage 0 holds 12, stage 1 receives two bubbles, older entries reach stage 2 unchanged.
- Flush+stall: both high with valid input addr 5 → next cycle stage_we[0]=0, stage_we[1]=0, and stage 2 receives the old stage 1.
